// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: RV M-extension
// funct3 encodings, FSM states and operand-signedness helpers.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic op_is_div(op_e op);
    return op[2];
  endfunction

  function automatic logic op_is_rem(op_e op);
    return op[2] & op[1];
  endfunction

  function automatic logic op1_signed(op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op2_signed(op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Request/result handshake bundle of the multiply/divide unit.
interface mdu_if
  import mdu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int TAGW = 5
) ();

  logic            i_valid;
  logic            o_ready;
  op_e             i_op;
  logic [XLEN-1:0] i_op1;
  logic [XLEN-1:0] i_op2;
  logic [TAGW-1:0] i_tag;
  logic            i_flush;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_result;
  logic [TAGW-1:0] o_tag;

  modport slave (
    input  i_valid, i_op, i_op1, i_op2, i_tag, i_flush, i_ready,
    output o_ready, o_valid, o_result, o_tag
  );

  modport master (
    output i_valid, i_op, i_op1, i_op2, i_tag, i_flush, i_ready,
    input  o_ready, o_valid, o_result, o_tag
  );

endinterface

// File: rtl/cond_negate.sv
// Two's-complement negate of a W-bit value when en is set, pass-through otherwise.
module cond_negate #(
  parameter int W = 32
) (
  input  logic         en,
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);

  assign y = en ? (~a + W'(1)) : a;

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV M-extension multiply/divide: one bit per cycle on operand
// magnitudes, sign restored at the end; divide-by-zero and overflow bypass.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int TAGW = 5
) (
  input logic  i_clk,
  input logic  i_rst,
  mdu_if.slave bus
);

  localparam int CW = $clog2(XLEN);

  state_e            state, state_nxt;
  op_e               op_q;
  logic              res_neg;
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   opnd, acc_hi, acc_lo, hi_nxt, lo_nxt;
  logic [XLEN-1:0]   mag1, mag2, bypass_res, final_res, res;
  logic [TAGW-1:0]   tag_q;
  logic [XLEN:0]     sum, shifted, diff;
  logic [2*XLEN-1:0] fix_in, fix_out;
  logic              accept, neg1, neg2, div0, ovf, last;

  assign accept = bus.i_valid && (state == S_IDLE) && !bus.i_flush;
  assign neg1   = op1_signed(bus.i_op) & bus.i_op1[XLEN-1];
  assign neg2   = op2_signed(bus.i_op) & bus.i_op2[XLEN-1];
  assign div0   = op_is_div(bus.i_op) && (bus.i_op2 == '0);
  assign ovf    = ((bus.i_op == OP_DIV) || (bus.i_op == OP_REM)) &&
                  (bus.i_op1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.i_op2 == '1);
  assign last   = (cnt == CW'(XLEN-1));

  always_comb begin
    bypass_res = '0;
    if (div0)
      bypass_res = op_is_rem(bus.i_op) ? bus.i_op1 : '1;
    else
      bypass_res = op_is_rem(bus.i_op) ? '0 : bus.i_op1;
  end

  cond_negate #(.W(XLEN)) u_neg_op1 (.en(neg1), .a(bus.i_op1), .y(mag1));
  cond_negate #(.W(XLEN)) u_neg_op2 (.en(neg2), .a(bus.i_op2), .y(mag2));

  // Multiply: {acc_hi, acc_lo} shifts right, multiplier in acc_lo, partial
  // product grows into acc_hi. Divide: acc_hi is the remainder, acc_lo the
  // dividend shifting out while quotient bits shift in.
  always_comb begin
    sum     = {1'b0, acc_hi} + {1'b0, opnd};
    shifted = {acc_hi, acc_lo[XLEN-1]};
    diff    = shifted - {1'b0, opnd};
    hi_nxt  = acc_hi;
    lo_nxt  = acc_lo;
    fix_in  = '0;
    if (op_is_div(op_q)) begin
      if (shifted >= {1'b0, opnd}) begin
        hi_nxt = diff[XLEN-1:0];
        lo_nxt = {acc_lo[XLEN-2:0], 1'b1};
      end else begin
        hi_nxt = shifted[XLEN-1:0];
        lo_nxt = {acc_lo[XLEN-2:0], 1'b0};
      end
      fix_in = {{XLEN{1'b0}}, (op_is_rem(op_q) ? hi_nxt : lo_nxt)};
    end else begin
      if (acc_lo[0])
        {hi_nxt, lo_nxt} = {sum, acc_lo[XLEN-1:1]};
      else
        {hi_nxt, lo_nxt} = {1'b0, acc_hi, acc_lo[XLEN-1:1]};
      fix_in = {hi_nxt, lo_nxt};
    end
  end

  cond_negate #(.W(2*XLEN)) u_fix (.en(res_neg), .a(fix_in), .y(fix_out));

  assign final_res = ((op_q == OP_MUL) || op_is_div(op_q)) ? fix_out[XLEN-1:0]
                                                            : fix_out[2*XLEN-1:XLEN];

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = (div0 || ovf) ? S_DONE : S_CALC;
      S_CALC:  if (last) state_nxt = S_DONE;
      S_DONE:  if (bus.i_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (bus.i_flush) state_nxt = S_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      op_q    <= bus.i_op;
      opnd    <= op_is_div(bus.i_op) ? mag2 : mag1;
      acc_hi  <= '0;
      acc_lo  <= op_is_div(bus.i_op) ? mag1 : mag2;
      cnt     <= '0;
      res_neg <= op_is_rem(bus.i_op) ? neg1 : (neg1 ^ neg2);
    end else if (state == S_CALC) begin
      acc_hi <= hi_nxt;
      acc_lo <= lo_nxt;
      cnt    <= cnt + 1'b1;
    end
  end

  // Result and tag only change on accept or the final CALC edge, so they
  // hold steady for as long as the consumer stalls in DONE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      res   <= '0;
      tag_q <= '0;
    end else if (accept) begin
      tag_q <= bus.i_tag;
      if (div0 || ovf) res <= bypass_res;
    end else if ((state == S_CALC) && last) begin
      res <= final_res;
    end
  end

  assign bus.o_ready  = (state == S_IDLE);
  assign bus.o_valid  = (state == S_DONE);
  assign bus.o_result = res;
  assign bus.o_tag    = tag_q;

endmodule
